vote_session_ctrl: RTL

//   Sequences one voting session around the 7-way majority datapath.

---
 rtl/vote_session_ctrl_pkg.sv | 11 +
 rtl/vote_session_ctrl_if.sv | 26 ++
 rtl/vote_tally.sv | 21 ++
 rtl/vote_session_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/vote_session_ctrl_pkg.sv
// vote_session_ctrl_pkg: shared defaults and FSM state encoding for the voting session controller
package vote_session_ctrl_pkg;
  localparam int N_VOTERS_DEF = 7;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_TALLY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/vote_session_ctrl_if.sv
// vote_session_ctrl_if: session control, ballot handshake and result bundle
interface vote_session_ctrl_if #(
  parameter int N_VOTERS = vote_session_ctrl_pkg::N_VOTERS_DEF,
  parameter int CNT_W = $clog2(N_VOTERS + 1)
);
  logic                start;
  logic                abort;
  logic [N_VOTERS-1:0] vote_valid;
  logic [N_VOTERS-1:0] vote_val;
  logic [N_VOTERS-1:0] vote_ack;
  logic                voting_open;
  logic                busy;
  logic                result_valid;
  logic                result;
  logic [CNT_W-1:0]    yes_count;
  logic [CNT_W-1:0]    turnout;
  logic                timed_out;
  modport master (
    output start, abort, vote_valid, vote_val,
    input  vote_ack, voting_open, busy, result_valid, result, yes_count, turnout, timed_out
  );
  modport slave (
    input  start, abort, vote_valid, vote_val,
    output vote_ack, voting_open, busy, result_valid, result, yes_count, turnout, timed_out
  );
endinterface

// File: rtl/vote_tally.sv
// vote_tally: counts yes ballots and turnout, flags a strict majority of the whole electorate
module vote_tally #(
  parameter int N_VOTERS = 7,
  parameter int CNT_W = $clog2(N_VOTERS + 1)
) (
  input  logic [N_VOTERS-1:0] ballot_i,
  input  logic [N_VOTERS-1:0] voted_i,
  output logic [CNT_W-1:0]    yes_count_o,
  output logic [CNT_W-1:0]    turnout_o,
  output logic                majority_o
);
  always_comb begin
    yes_count_o = '0;
    turnout_o = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      yes_count_o = yes_count_o + CNT_W'(ballot_i[i] & voted_i[i]);
      turnout_o = turnout_o + CNT_W'(voted_i[i]);
    end
  end
  assign majority_o = int'(yes_count_o) > N_VOTERS / 2;
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: opens a ballot window, collects one ballot per voter, tallies and publishes the verdict
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter int N_VOTERS = N_VOTERS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = $clog2(N_VOTERS + 1),
  parameter int TMR_W = $clog2(TIMEOUT + 1)
) (
  input logic clk,
  input logic rst_n,
  vote_session_ctrl_if.slave bus
);
  state_e              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d, ballot_q, ballot_d, ack;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    yes_q, yes_d, turnout_q, turnout_d, tally_yes, tally_turnout;
  logic                result_q, result_d, timed_out_q, timed_out_d, tally_maj;

  vote_tally #(.N_VOTERS(N_VOTERS), .CNT_W(CNT_W)) u_tally (
    .ballot_i    (ballot_q),
    .voted_i     (voted_q),
    .yes_count_o (tally_yes),
    .turnout_o   (tally_turnout),
    .majority_o  (tally_maj)
  );

  assign ack = state_q == ST_OPEN ? bus.vote_valid & ~voted_q : '0;

  always_comb begin
    state_d = state_q;
    voted_d = voted_q;
    ballot_d = ballot_q;
    timer_d = timer_q;
    result_d = result_q;
    yes_d = yes_q;
    turnout_d = turnout_q;
    timed_out_d = timed_out_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      voted_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          state_d = ST_OPEN;
          voted_d = '0;
          ballot_d = '0;
          timer_d = TMR_W'(TIMEOUT);
          result_d = 1'b0;
          yes_d = '0;
          turnout_d = '0;
          timed_out_d = 1'b0;
        end
        ST_OPEN: begin
          voted_d = voted_q | ack;
          ballot_d = (ballot_q & ~ack) | (bus.vote_val & ack);
          timer_d = timer_q - 1'b1;
          state_d = (&(voted_q | ack) || timer_q == TMR_W'(1)) ? ST_TALLY : ST_OPEN;
        end
        ST_TALLY: begin
          state_d = ST_DONE;
          yes_d = tally_yes;
          turnout_d = tally_turnout;
          result_d = tally_maj;
          timed_out_d = ~&voted_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      voted_q <= '0;
      ballot_q <= '0;
      timer_q <= '0;
      result_q <= 1'b0;
      yes_q <= '0;
      turnout_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      voted_q <= voted_d;
      ballot_q <= ballot_d;
      timer_q <= timer_d;
      result_q <= result_d;
      yes_q <= yes_d;
      turnout_q <= turnout_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.vote_ack = ack;
  assign bus.voting_open = state_q == ST_OPEN;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.result_valid = state_q == ST_DONE && !bus.abort;
  assign bus.result = result_q;
  assign bus.yes_count = yes_q;
  assign bus.turnout = turnout_q;
  assign bus.timed_out = timed_out_q;
endmodule
